// File: rtl/diag_block_feeder.sv
// Fetches one diagonal-packed matrix block from memory and streams it as (value, diag, offset) elements.
// Latency: 2 cycles per header plus 6 cycles per data word; one memory read outstanding at a time.
// Backpressure: the element on the output is held stable while out_ready is low.
module diag_block_feeder #(
    parameter int XBAR_SIZE      = 32,
    parameter int XBAR_DIM_WIDTH = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      err_flag,
    output logic [XBAR_DIM_WIDTH:0]   diag_count,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [MEM_WIDTH-1:0]      mem_rdata,
    input  logic                      mem_rvalid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     b_value_out,
    output logic [XBAR_DIM_WIDTH-1:0] b_diag_out,
    output logic [XBAR_DIM_WIDTH-1:0] b_offset_out,
    output logic                      block_valid_out,
    output logic                      new_diagonal_out
);
    localparam int WPD = XBAR_SIZE / 4;
    localparam int WW  = XBAR_DIM_WIDTH - 2;
    localparam int DCW = XBAR_DIM_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE, HDR_REQ, HDR_WAIT, DAT_REQ, DAT_WAIT, EMIT, FIN
    } state_t;

    state_t                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic [XBAR_DIM_WIDTH-1:0] diag;
    logic                      last;
    logic [WW-1:0]             w;
    logic [1:0]                k;
    logic [MEM_WIDTH-1:0]      sbuf;
    logic                      hdr_bad;
    logic                      emit;
    logic                      last_word;

    // A 33rd header without a preceding last flag is treated like a malformed header.
    assign hdr_bad   = (mem_rdata[MEM_WIDTH-2:XBAR_DIM_WIDTH] != '0) ||
                       (diag_count == DCW'(XBAR_SIZE));
    assign emit      = (state == EMIT);
    assign last_word = (w == WW'(WPD - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = HDR_REQ;
            HDR_REQ:  state_nxt = HDR_WAIT;
            HDR_WAIT: if (mem_rvalid) state_nxt = hdr_bad ? IDLE : DAT_REQ;
            DAT_REQ:  state_nxt = DAT_WAIT;
            DAT_WAIT: if (mem_rvalid) state_nxt = EMIT;
            EMIT: begin
                if (out_ready && k == 2'd3) begin
                    if (!last_word) state_nxt = DAT_REQ;
                    else if (last)  state_nxt = FIN;
                    else            state_nxt = HDR_REQ;
                end
            end
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cur_addr   <= '0;
            diag       <= '0;
            last       <= 1'b0;
            w          <= '0;
            k          <= '0;
            sbuf       <= '0;
            diag_count <= '0;
            err_flag   <= 1'b0;
            error      <= 1'b0;
        end else begin
            state <= state_nxt;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr   <= base_addr;
                        err_flag   <= 1'b0;
                        diag_count <= '0;
                    end
                end
                HDR_REQ, DAT_REQ: cur_addr <= cur_addr + ADDR_WIDTH'(4);
                HDR_WAIT: begin
                    if (mem_rvalid) begin
                        if (hdr_bad) begin
                            error    <= 1'b1;
                            err_flag <= 1'b1;
                        end else begin
                            diag <= mem_rdata[XBAR_DIM_WIDTH-1:0];
                            last <= mem_rdata[MEM_WIDTH-1];
                            w    <= '0;
                        end
                    end
                end
                DAT_WAIT: begin
                    if (mem_rvalid) begin
                        sbuf <= mem_rdata;
                        k    <= '0;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        sbuf <= sbuf >> DATA_WIDTH;
                        k    <= k + 2'd1;
                        if (k == 2'd3) begin
                            if (last_word) diag_count <= diag_count + DCW'(1);
                            else           w <= w + WW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign done             = (state == FIN);
    assign mem_rd_en        = (state == HDR_REQ) || (state == DAT_REQ);
    assign mem_addr         = mem_rd_en ? cur_addr : '0;
    assign block_valid_out  = emit;
    assign b_value_out      = emit ? sbuf[DATA_WIDTH-1:0] : '0;
    assign b_diag_out       = emit ? diag : '0;
    assign b_offset_out     = emit ? {w, k} : '0;
    assign new_diagonal_out = emit && (w == '0) && (k == 2'd0);

endmodule

// File: tb/tb_diag_block_feeder.sv
// Randomised scoreboard bench: a memory image is built, a reference walk of it queues the
// expected reads and elements, and independent monitors compare them against the DUT.
module tb_diag_block_feeder;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        busy, done, error, err_flag;
    logic [5:0]  diag_count;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  b_value_out;
    logic [4:0]  b_diag_out, b_offset_out;
    logic        block_valid_out, new_diagonal_out;

    typedef struct packed {
        logic [7:0] v;
        logic [4:0] d;
        logic [4:0] o;
        logic       nd;
    } elem_t;

    elem_t       exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] mem [int unsigned];
    int          tot = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          lat_mode = 0;
    bit          outstanding = 0;
    int          cnt = 0;
    logic [31:0] pa = '0;
    bit          stalled = 0;
    elem_t       held;
    elem_t       cur;

    diag_block_feeder dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .error(error), .err_flag(err_flag),
        .diag_count(diag_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_ready(out_ready),
        .b_value_out(b_value_out), .b_diag_out(b_diag_out), .b_offset_out(b_offset_out),
        .block_valid_out(block_valid_out), .new_diagonal_out(new_diagonal_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cur = {b_value_out, b_diag_out, b_offset_out, new_diagonal_out};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Memory: one response per read after 1 (or 1..5) cycles; spurious rvalid only when nothing is pending.
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            outstanding = 0;
            mem_rvalid  = 1'b0;
        end else begin
            if (mem_rd_en) begin
                chk("one_outstanding", outstanding, 0);
                if (addr_q.size() == 0) begin
                    tot++; bad++;
                    $display("FAIL mem_addr: got read at %0h expected no read", mem_addr);
                end else begin
                    chk("mem_addr", mem_addr, addr_q.pop_front());
                end
            end
            mem_rvalid = 1'b0;
            if (outstanding) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid  = 1'b1;
                    mem_rdata   = rd_word(pa);
                    outstanding = 0;
                end
            end else if (lat_mode == 1 && $urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end
            if (mem_rd_en) begin
                outstanding = 1;
                pa  = mem_addr;
                cnt = (lat_mode == 1) ? $urandom_range(1, 5) : 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Element monitor: pops on each accepted element and checks stability across stalls.
    always @(negedge clk) begin
        if (!rstn) begin
            stalled = 0;
        end else begin
            if (stalled) chk("stall_hold", {block_valid_out, cur}, {1'b1, held});
            if (block_valid_out) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        tot++; bad++;
                        $display("FAIL element: got %0h expected no element", cur);
                    end else begin
                        chk("element", cur, exp_q.pop_front());
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = cur;
                end
            end else begin
                chk("nd_idle", new_diagonal_out, 0);
            end
        end
    end

    task automatic put_diag(inout logic [31:0] a, input logic [31:0] hdr, input bit seq);
        logic [31:0] wd;
        mem[a] = hdr;
        a += 4;
        for (int wi = 0; wi < 8; wi++) begin
            for (int ki = 0; ki < 4; ki++)
                wd[8*ki +: 8] = seq ? 8'(4*wi + ki) : 8'($urandom);
            mem[a] = wd;
            a += 4;
        end
    endtask

    // Walks the memory image the way the block format describes it.
    task automatic model(input logic [31:0] base, output bit e_err, output int e_cnt);
        logic [31:0] a, h, wd;
        a = base; e_cnt = 0; e_err = 0;
        while (1) begin
            addr_q.push_back(a);
            h = rd_word(a);
            a += 4;
            if (h[30:5] != 0 || e_cnt == 32) begin
                e_err = 1;
                break;
            end
            for (int wi = 0; wi < 8; wi++) begin
                addr_q.push_back(a);
                wd = rd_word(a);
                a += 4;
                for (int ki = 0; ki < 4; ki++)
                    exp_q.push_back(elem_t'({wd[8*ki +: 8], h[4:0], 5'(4*wi + ki), (4*wi + ki) == 0}));
            end
            e_cnt++;
            if (h[31]) break;
        end
    endtask

    task automatic run_block(input string nm, input logic [31:0] base, input int rm, input int lm,
                             input bit poke, output int lat);
        bit e_err, g_done, g_err;
        int e_cnt, s;
        rdy_mode = rm;
        lat_mode = lm;
        model(base, e_err, e_cnt);
        @(negedge clk);
        start = 1'b1; base_addr = base; s = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "/busy"}, busy, 1);
        chk({nm, "/err_flag_clr"}, err_flag, 0);
        g_done = 0; g_err = 0; lat = -1;
        for (int i = 0; i < 6000 && !g_done && !g_err; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && i == 30) begin
                start = 1'b1;
                base_addr = 32'hdead_0000;
            end
            if (done || error) begin
                g_done = done; g_err = error; lat = cyc - s;
                chk({nm, "/done_xor_error"}, done & error, 0);
            end
        end
        start = 1'b0;
        if (!g_done && !g_err) begin
            tot++; bad++;
            $display("FAIL %s/timeout: got no done or error, expected one within 6000 cycles", nm);
        end else begin
            chk({nm, "/error"}, g_err, e_err);
            chk({nm, "/diag_count"}, diag_count, e_cnt);
            chk({nm, "/err_flag"}, err_flag, e_err);
            chk({nm, "/elems_left"}, exp_q.size(), 0);
            chk({nm, "/reads_left"}, addr_q.size(), 0);
        end
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        chk({nm, "/idle"}, {busy, done, error}, 3'b000);
    endtask

    initial begin
        logic [31:0] a;
        int  lat;
        bit  e_err, seen;
        int  e_cnt;

        repeat (3) @(negedge clk);
        chk("rst/busy", busy, 0);
        chk("rst/flags", {done, error, err_flag}, 0);
        chk("rst/diag_count", diag_count, 0);
        chk("rst/mem", {mem_rd_en, mem_addr}, 0);
        chk("rst/stream", {block_valid_out, cur}, 0);
        rstn = 1'b1;

        a = 32'h1000; put_diag(a, 32'h8000_0003, 1);
        a = 32'h2000;
        put_diag(a, 32'h0000_0000, 0);
        put_diag(a, 32'h0000_0005, 0);
        put_diag(a, 32'h8000_001f, 0);
        mem[32'h3000] = 32'h0000_0100;
        a = 32'h4000;
        for (int i = 0; i < 33; i++) put_diag(a, 32'(i % 32), 0);
        a = 32'h6000; put_diag(a, 32'h8000_0011, 0);

        // done lands in the 52nd cycle counting the start cycle as the first
        run_block("single", 32'h1000, 0, 0, 0, lat);
        chk("single/start_to_done", lat, 51);
        run_block("three", 32'h2000, 2, 1, 1, lat);
        run_block("toggle_bp", 32'h1000, 1, 0, 0, lat);
        chk("toggle_bp/delayed", lat > 51, 1);
        run_block("var_lat", 32'h1000, 0, 1, 0, lat);
        run_block("bad_hdr", 32'h3000, 0, 0, 0, lat);
        run_block("after_bad", 32'h2000, 0, 1, 0, lat);
        run_block("no_last", 32'h4000, 0, 0, 0, lat);

        rdy_mode = 2; lat_mode = 1;
        model(32'h6000, e_err, e_cnt);
        @(negedge clk);
        start = 1'b1; base_addr = 32'h6000;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = block_valid_out;
        end
        chk("rst_mid/reached_emit", seen, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid/busy", busy, 0);
        chk("rst_mid/flags", {done, error, err_flag}, 0);
        chk("rst_mid/diag_count", diag_count, 0);
        chk("rst_mid/mem", {mem_rd_en, mem_addr}, 0);
        chk("rst_mid/stream", {block_valid_out, cur}, 0);
        repeat (2) @(negedge clk);
        chk("rst_mid/held_idle", {busy, done, error, block_valid_out}, 0);
        exp_q.delete();
        addr_q.delete();
        rstn = 1'b1;
        run_block("after_rst", 32'h1000, 2, 1, 0, lat);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no summary, expected completion before 600000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/diag_block_feeder.md
Name: diag_block_feeder

Overview:
- Upstream stage of the crossbar controller (mcc).
- Fetches one diagonal-packed matrix block from main memory and streams it element by element as (b_value, b_diag, b_offset) tuples with block_valid / new_diagonal strobes, matching mcc's b_* inputs.
- Issues one memory read at a time, unpacks 4 bytes per word, honours downstream backpressure, and reports completion or format error.

Parameters:
- XBAR_SIZE, 32, crossbar dimension; elements per diagonal. Must be a multiple of 4.
- XBAR_DIM_WIDTH, 5, log2(XBAR_SIZE).
- DATA_WIDTH, 8, element width. Fixed at 8 because of the 4-byte packing.
- ADDR_WIDTH, 32, byte address width.
- MEM_WIDTH, 32, memory word width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin fetch at base_addr
- base_addr  in  ADDR_WIDTH  byte address of the first header word; word aligned
- busy  out  1  high from accepted start until done/error
- done  out  1  one-cycle pulse after the last element is emitted
- error  out  1  one-cycle pulse on a format error; sticky copy in err_flag
- err_flag  out  1  set on error, cleared by next accepted start
- diag_count  out  XBAR_DIM_WIDTH+1  diagonals fully emitted in the current or last block
- mem_rd_en  out  1  one-cycle read request
- mem_addr  out  ADDR_WIDTH  read address, valid with mem_rd_en
- mem_rdata  in  MEM_WIDTH  read data
- mem_rvalid  in  1  read data valid; arrives one or more cycles after mem_rd_en
- out_ready  in  1  downstream accepts element; tied high when driving mcc
- b_value_out  out  DATA_WIDTH  element value
- b_diag_out  out  XBAR_DIM_WIDTH  diagonal index of current element
- b_offset_out  out  XBAR_DIM_WIDTH  position within the diagonal, 0..XBAR_SIZE-1
- block_valid_out  out  1  element valid
- new_diagonal_out  out  1  high with the offset-0 element of each diagonal

Behaviour:
- Memory format, per diagonal:
  - Header word: [4:0] diag index; [31] last-diagonal flag; [30:5] reserved, must be 0.
  - Then XBAR_SIZE/4 data words. Byte k of the word (bits 8k+7:8k) is the element at offset 4*w+k.
  - Diagonals are contiguous; the address increments by 4 per word.
- Reset: all outputs 0, FSM in IDLE, counters 0, err_flag 0.
- FSM states: IDLE, HDR_REQ, HDR_WAIT, DAT_REQ, DAT_WAIT, EMIT, FIN.
  - IDLE: start=1 → latch base_addr, clear err_flag and diag_count, go to HDR_REQ. start while busy is ignored.
  - HDR_REQ: mem_rd_en=1 for 1 cycle at cur_addr; cur_addr+=4; go to HDR_WAIT.
  - HDR_WAIT: on mem_rvalid, check header.
    - Reserved bits nonzero → pulse error, go to IDLE.
    - Otherwise latch diag and last flag, set word counter w=0, go to DAT_REQ.
  - DAT_REQ: mem_rd_en=1 for 1 cycle; cur_addr+=4; go to DAT_WAIT.
  - DAT_WAIT: on mem_rvalid, capture the word into a 32-bit shift buffer, set byte index k=0, go to EMIT.
  - EMIT: drive block_valid_out=1, b_value=byte k, b_offset=4*w+k, b_diag=latched diag, new_diagonal_out=(offset==0).
    - An element advances only when out_ready=1; outputs hold stable while out_ready=0.
    - After k=3 is accepted:
      - If w < XBAR_SIZE/4-1: w++, go to DAT_REQ.
      - Else: diag_count++. If last flag set → FIN, else HDR_REQ.
  - FIN: done=1 for 1 cycle, go to IDLE.
- block_valid_out and new_diagonal_out are 0 in every state other than EMIT.
- Guard: if diag_count would exceed XBAR_SIZE without a last flag (33rd header fetched), pulse error and go to IDLE without emitting that diagonal.
- mem_rvalid is ignored outside HDR_WAIT and DAT_WAIT.
- Only one read is outstanding at a time; mem_rd_en never reasserts before rvalid.
- busy=1 in every state except IDLE. done and error are mutually exclusive.
- Latency with rvalid one cycle after rd_en and out_ready=1:
  - Per diagonal: 2 (header) + 8×(2+4) = 50 cycles.
  - One diagonal, start to done: 1 + 50 + 1.
- Asynchronous reset mid-block: immediate return to IDLE and all outputs 0. No done or error pulse.

Test Plan:
- Single diagonal: header 0x8000_0003, data bytes 0..31, rvalid latency 1, out_ready=1 → 32 elements, diag=3, offsets 0..31, values 0..31; new_diagonal only at offset 0; done 52 cycles after start; diag_count=1; addresses base..base+32.
- Three diagonals (diag 0, 5, 31, last flag on the third) → 96 elements, new_diagonal pulses exactly 3 times, diag_count=3, one done pulse.
- Backpressure: toggle out_ready 1/0 every cycle on the single-diagonal block → identical element sequence, outputs stable while stalled, done delayed accordingly.
- Variable rvalid latency 1..5 with random spurious rvalid in other states → output stream unchanged; one outstanding mem_rd_en at a time.
- Bad header 0x0000_0100 → error pulse, err_flag=1, no elements; next start with a valid block clears err_flag and completes normally.
- No last flag across 33 headers → error after 32 diagonals, diag_count=32. Separately, assert rstn low mid-EMIT → all outputs 0 immediately, FSM in IDLE, and a start pulse issued while busy produces no effect.
